// File: rtl/l1i_mau_pkg.sv
// Shared definitions for the L1I miss-refill unit: core geometry, state encoding, bus width default.
`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_OFFSET_WIDTH
`define CORE_OFFSET_WIDTH 4
`endif
`ifndef L1_LINE_SIZE
`define L1_LINE_SIZE 128
`endif

package l1i_mau_pkg;
    localparam int ADDR_W             = `CORE_ADDR_WIDTH;
    localparam int OFFSET_W           = `CORE_OFFSET_WIDTH;
    localparam int LINE_W             = `L1_LINE_SIZE;
    localparam int BUS_DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } mau_state_e;
endpackage

// File: rtl/l1i_mau.sv
// L1I miss-refill unit: splits a line fill into bus beats and returns the assembled line.
// Optional last-line buffer enabled by defining L1I_MAU_LINE_BUF_EN.
module l1i_mau
    import l1i_mau_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = BUS_DATA_WIDTH_DEF,
    parameter int BEATS          = LINE_W / BUS_DATA_WIDTH,
    parameter int CNT_W          = $clog2(BEATS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mau_req_val,
    input  logic [ADDR_W-1:0]         mau_req_addr,
    output logic                      mau_req_ack,
    output logic [LINE_W-1:0]         mau_ack_data,
    output logic                      mem_req_val,
    output logic [ADDR_W-1:0]         mem_req_addr,
    input  logic                      mem_req_ack,
    input  logic                      mem_rsp_val,
    input  logic [BUS_DATA_WIDTH-1:0] mem_rsp_data
);
    typedef logic [ADDR_W-1:0] addr_t;

    localparam int   BYTE_W      = $clog2(BUS_DATA_WIDTH / 8);
    localparam addr_t OFFSET_MSK = addr_t'((1 << OFFSET_W) - 1);

    mau_state_e         state, state_nxt;
    addr_t              addr_r;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  line_r;
    logic               accept;
    logic               beat_wr;
    logic               last_beat;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));

`ifdef L1I_MAU_LINE_BUF_EN
    logic  lb_val;
    addr_t lb_addr;
    logic  lb_hit;

    assign lb_hit = lb_val && (mau_req_addr == lb_addr);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        beat_wr      = 1'b0;
        mem_req_val  = 1'b0;
        mem_req_addr = '0;
        mau_req_ack  = 1'b0;
        mau_ack_data = '0;
        case (state)
            IDLE: begin
                if (mau_req_val) begin
`ifdef L1I_MAU_LINE_BUF_EN
                    if (lb_hit) begin
                        state_nxt = DONE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end
`else
                    accept    = 1'b1;
                    state_nxt = REQ;
`endif
                end
            end
            REQ: begin
                // addr_r has zero offset bits, so OR-ing in the beat index forms the beat address
                mem_req_val  = 1'b1;
                mem_req_addr = addr_r | (addr_t'(cnt) << BYTE_W);
                if (mem_req_ack) state_nxt = RSP;
            end
            RSP: begin
                if (mem_rsp_val) begin
                    beat_wr   = 1'b1;
                    state_nxt = last_beat ? DONE : REQ;
                end
            end
            DONE: begin
                mau_req_ack  = 1'b1;
                mau_ack_data = line_r;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            cnt    <= '0;
            line_r <= '0;
        end else begin
            if (accept) begin
                addr_r <= mau_req_addr & ~OFFSET_MSK;
                cnt    <= '0;
            end
            if (beat_wr) begin
                line_r[int'(cnt)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= mem_rsp_data;
                if (!last_beat) cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef L1I_MAU_LINE_BUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_val  <= 1'b0;
            lb_addr <= '0;
        end else if (beat_wr && last_beat) begin
            lb_val  <= 1'b1;
            lb_addr <= addr_r;
        end
    end
`endif

`ifndef SYNTHESYS
    ack_one_hot: assert property (@(posedge clk) disable iff (!rst_n)
        mau_req_ack |=> !mau_req_ack);

    req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_req_val && !mem_req_ack) |=> (mem_req_val && $stable(mem_req_addr)));

    // A beat arriving with no request outstanding is dropped; flag it without stopping
    rsp_only_in_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_val |-> (state == RSP))
        else $warning("l1i_mau: mem_rsp_val outside RSP ignored");
`endif
endmodule

// File: tb/tb_l1i_mau.sv
// Directed bench for l1i_mau: table of refills over a scripted bus plus reset, spurious-beat and line-buffer sequences.
module tb_l1i_mau;
    import l1i_mau_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mau_req_val;
    logic [31:0]       mau_req_addr;
    logic              mau_req_ack;
    logic [LINE_W-1:0] mau_ack_data;
    logic              mem_req_val;
    logic [31:0]       mem_req_addr;
    logic              mem_req_ack;
    logic              mem_rsp_val;
    logic [31:0]       mem_rsp_data;

    l1i_mau dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mau_req_val  (mau_req_val),
        .mau_req_addr (mau_req_addr),
        .mau_req_ack  (mau_req_ack),
        .mau_ack_data (mau_ack_data),
        .mem_req_val  (mem_req_val),
        .mem_req_addr (mem_req_addr),
        .mem_req_ack  (mem_req_ack),
        .mem_rsp_val  (mem_rsp_val),
        .mem_rsp_data (mem_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       addr;
        logic [3:0][31:0]  beat;
        logic [3:0][3:0]   req_wait;
        logic [3:0][3:0]   rsp_wait;
        logic [7:0]        exp_cyc;
        logic [127:0]      exp_data;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scripted memory bus
    logic             bus_en = 1'b0;
    logic             spur   = 1'b0;
    logic [31:0]      base;
    logic [3:0][31:0] cur_beats;
    logic [3:0][3:0]  cur_req_wait;
    logic [3:0][3:0]  cur_rsp_wait;
    int               bidx, req_dly, rsp_dly, acc_cnt;
    bit               pend;

    always @(negedge clk) begin
        if (bus_en) begin
            mem_req_ack  = 1'b0;
            mem_rsp_val  = 1'b0;
            mem_rsp_data = '0;
            if (pend) begin
                chk("req_during_rsp", 128'(mem_req_val), 128'(0));
                if (rsp_dly > 0) begin
                    rsp_dly--;
                end else begin
                    mem_rsp_val  = 1'b1;
                    mem_rsp_data = cur_beats[bidx];
                    pend         = 1'b0;
                    bidx++;
                    if (bidx < 4) req_dly = int'(cur_req_wait[bidx]);
                end
            end else if (mem_req_val) begin
                if (bidx > 3) begin
                    chk("extra_beat_req", 128'(1), 128'(0));
                end else begin
                    chk("beat_addr", 128'(mem_req_addr), 128'(base + 32'(4 * bidx)));
                    if (req_dly > 0) begin
                        req_dly--;
                        if (spur) begin
                            mem_rsp_val  = 1'b1;
                            mem_rsp_data = '1;
                        end
                    end else begin
                        mem_req_ack = 1'b1;
                        pend        = 1'b1;
                        acc_cnt++;
                        rsp_dly     = int'(cur_rsp_wait[bidx]);
                    end
                end
            end
        end
    end

    task automatic bus_setup(input vec_t v, input logic spur_en);
        base         = v.addr;
        cur_beats    = v.beat;
        cur_req_wait = v.req_wait;
        cur_rsp_wait = v.rsp_wait;
        bidx         = 0;
        pend         = 1'b0;
        acc_cnt      = 0;
        req_dly      = int'(v.req_wait[0]);
        rsp_dly      = 0;
        spur         = spur_en;
        bus_en       = 1'b1;
    endtask

    // Raises the request in cycle 0 and returns the cycle of the ack (-1 if none).
    task automatic run_req(input vec_t v, input logic spur_en, output int cyc, output logic [127:0] data);
        bus_setup(v, spur_en);
        mau_req_val  = 1'b1;
        mau_req_addr = v.addr;
        @(posedge clk);
        #1 mau_req_addr = ~v.addr & 32'hFFFF_FFF0;
        cyc  = -1;
        data = '0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (mau_req_ack) begin
                cyc  = c;
                data = mau_ack_data;
                break;
            end
        end
        @(posedge clk);
        #1 mau_req_val = 1'b0;
    endtask

    vec_t vecs[4];
    vec_t v;
    int   cyc;
    logic [127:0] data;
    logic seen;

    initial begin
        rst_n        = 1'b0;
        mau_req_val  = 1'b0;
        mau_req_addr = '0;
        mem_req_ack  = 1'b0;
        mem_rsp_val  = 1'b0;
        mem_rsp_data = '0;

        vecs[0] = '{addr: 32'h0000_1230,
                    beat: {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0},
                    req_wait: 16'h0000, rsp_wait: 16'h0000, exp_cyc: 8'd9,
                    exp_data: 128'h000000A3_000000A2_000000A1_000000A0};
        vecs[1] = '{addr: 32'h0000_5670,
                    beat: {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0},
                    req_wait: 16'h0030, rsp_wait: 16'h0200, exp_cyc: 8'd14,
                    exp_data: 128'h000000A3_000000A2_000000A1_000000A0};
        vecs[2] = '{addr: 32'h0000_2000,
                    beat: {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                    req_wait: 16'h0000, rsp_wait: 16'h0000, exp_cyc: 8'd9,
                    exp_data: 128'h44444444_33333333_22222222_11111111};
        vecs[3] = '{addr: 32'h0000_ABC0,
                    beat: {32'hCAFE_F00D, 32'h89AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF},
                    req_wait: 16'h0102, rsp_wait: 16'h1001, exp_cyc: 8'd14,
                    exp_data: 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",      128'(mau_req_ack),  128'(0));
        chk("rst_req_val",  128'(mem_req_val),  128'(0));
        chk("rst_req_addr", 128'(mem_req_addr), 128'(0));
        chk("rst_ack_data", mau_ack_data,       128'(0));
        rst_n = 1'b1;

        // Stray beat while idle must not start anything
        @(negedge clk);
        mem_rsp_val  = 1'b1;
        mem_rsp_data = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rsp_val = 1'b0;
        chk("idle_spur_req", 128'(mem_req_val), 128'(0));
        chk("idle_spur_ack", 128'(mau_req_ack), 128'(0));
        @(posedge clk);
        #1;

        // Back-to-back refills, each raised the cycle after the previous ack
        for (int i = 0; i < 4; i++) begin
            run_req(vecs[i], (i == 1), cyc, data);
            chk($sformatf("v%0d_ack_cycle", i), 128'(cyc), 128'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
            chk($sformatf("v%0d_beats", i), 128'(acc_cnt), 128'(4));
        end

        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | mau_req_ack | mem_req_val;
        end
        chk("quiet_after_burst", 128'(seen), 128'(0));

        // Reset during the response phase of beat 2
        v = '{addr: 32'h0000_3000,
              beat: {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000},
              req_wait: 16'h0000, rsp_wait: 16'h0000, exp_cyc: 8'd0, exp_data: '0};
        bus_setup(v, 1'b0);
        mau_req_val  = 1'b1;
        mau_req_addr = v.addr;
        @(posedge clk);
        repeat (6) @(negedge clk);
        #1 chk("pre_rst_in_rsp", 128'(mem_rsp_val), 128'(1));
        #1;
        rst_n       = 1'b0;
        bus_en      = 1'b0;
        mem_rsp_val = 1'b0;
        mem_req_ack = 1'b0;
        mau_req_val = 1'b0;
        #1;
        chk("midrst_ack",      128'(mau_req_ack),  128'(0));
        chk("midrst_req_val",  128'(mem_req_val),  128'(0));
        chk("midrst_req_addr", 128'(mem_req_addr), 128'(0));
        chk("midrst_ack_data", mau_ack_data,       128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | mau_req_ack | mem_req_val;
        end
        chk("no_ack_aborted", 128'(seen), 128'(0));
        @(posedge clk);
        #1;
        v = '{addr: 32'h0000_0040,
              beat: {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0},
              req_wait: 16'h0000, rsp_wait: 16'h0000, exp_cyc: 8'd9,
              exp_data: 128'h000000C3_000000C2_000000C1_000000C0};
        run_req(v, 1'b0, cyc, data);
        chk("post_rst_cycle", 128'(cyc), 128'(9));
        chk("post_rst_data",  data, 128'h000000C3_000000C2_000000C1_000000C0);

        // Repeat of the same line: buffered when the line buffer is built in
        run_req(vecs[0], 1'b0, cyc, data);
        chk("lb_first_cycle", 128'(cyc), 128'(9));
        chk("lb_first_data",  data, vecs[0].exp_data);
        v = vecs[0];
        v.beat = {32'h0000_00E3, 32'h0000_00E2, 32'h0000_00E1, 32'h0000_00E0};
        run_req(v, 1'b0, cyc, data);
`ifdef L1I_MAU_LINE_BUF_EN
        chk("lb_hit_cycle", 128'(cyc), 128'(1));
        chk("lb_hit_data",  data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("lb_hit_beats", 128'(acc_cnt), 128'(0));
`else
        chk("repeat_cycle", 128'(cyc), 128'(9));
        chk("repeat_data",  data, 128'h000000E3_000000E2_000000E1_000000E0);
        chk("repeat_beats", 128'(acc_cnt), 128'(4));
`endif
        v = '{addr: 32'h0000_1240,
              beat: {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1, 32'h0000_00B0},
              req_wait: 16'h0000, rsp_wait: 16'h0000, exp_cyc: 8'd9,
              exp_data: 128'h000000B3_000000B2_000000B1_000000B0};
        run_req(v, 1'b0, cyc, data);
        chk("lb_miss_cycle", 128'(cyc), 128'(9));
        chk("lb_miss_data",  data, 128'h000000B3_000000B2_000000B1_000000B0);
        chk("lb_miss_beats", 128'(acc_cnt), 128'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/l1i_mau.md
Name: l1i_mau

Overview:
- Miss-refill unit sitting directly downstream of the L1 instruction cache.
- Accepts the cache's line-fill request (mau_req_val/mau_req_addr) and splits it into BUS_DATA_WIDTH beats on the memory bus.
- Assembles the returned beats into one L1_LINE_SIZE line and returns it with a single-cycle mau_req_ack, with mau_ack_data valid in that cycle.

Parameters:
- BUS_DATA_WIDTH, 32: memory bus data width in bits; must divide `L1_LINE_SIZE.
- BEATS, `L1_LINE_SIZE/BUS_DATA_WIDTH: beats per line; must be a power of 2 and at least 2.
- CNT_W, $clog2(BEATS): width of the beat counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mau_req_val  in  1  line-fill request; held high by L1I until mau_req_ack.
- mau_req_addr  in  `CORE_ADDR_WIDTH  line address; offset bits are zero.
- mau_req_ack  out  1  one-cycle pulse: line delivered.
- mau_ack_data  out  `L1_LINE_SIZE  assembled line; valid only while mau_req_ack=1.
- mem_req_val  out  1  bus read request for one beat.
- mem_req_addr  out  `CORE_ADDR_WIDTH  beat byte address.
- mem_req_ack  in  1  bus accepted the request in this cycle.
- mem_rsp_val  in  1  beat data valid.
- mem_rsp_data  in  BUS_DATA_WIDTH  beat data.

Behaviour:
- Clocking/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. Reset forces state=IDLE, beat counter=0 and line buffer=0, and drives mau_req_ack=0, mem_req_val=0. mem_req_addr and mau_ack_data read 0 after reset.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - If mau_req_val=1: latch addr_r = mau_req_addr with the offset bits forced to 0, clear cnt, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req_val=1.
  - mem_req_addr = {addr_r[hi:CORE_OFFSET_WIDTH], cnt, 2'b00} (word-granular for the default width).
  - Address and val are held stable until mem_req_ack=1, then go to RSP.
- RSP:
  - On mem_rsp_val=1: write line_r[cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = mem_rsp_data. Beat 0 occupies the lowest bits, matching the cache's byte-offset select.
  - If cnt==BEATS-1, go to DONE. Otherwise cnt=cnt+1 and go to REQ.
  - cnt never wraps inside a line.
- DONE:
  - mau_req_ack=1 and mau_ack_data=line_r for exactly one cycle, then go to IDLE.
  - mau_req_val still high during DONE is not a new request.
- Sampling rule: a new request is sampled only in IDLE. L1I drops mau_req_val the cycle after the ack.
- Latency: with a zero-wait bus (mem_req_ack in the same cycle as the request, mem_rsp_val the next cycle), acceptance is at cycle 0 and the ack is at cycle 2*BEATS+1. Each bus wait cycle adds exactly one cycle.
- Only one bus request is outstanding at a time. mem_req_val is never high in RSP.
- mem_rsp_val outside RSP is ignored and flagged by an assertion.
- mem_req_ack outside REQ is ignored.
- mau_req_addr changing while busy is ignored; addr_r is authoritative.
- Reset asserted mid-burst aborts the burst immediately. The bus side must share rst_n. No ack is issued for the aborted request.
- Assertions (suppressed under SYNTHESYS):
  - mau_req_ack is one-hot in time (never high two cycles in a row).
  - mem_req_val stable with stable address until mem_req_ack.

Optional Feature:
- Macro: L1I_MAU_LINE_BUF_EN.
- When defined:
  - Keeps lb_val and lb_addr, the address of the last delivered line.
  - In IDLE, if mau_req_val=1, lb_val=1 and mau_req_addr==lb_addr: go directly to DONE with no bus activity. The ack arrives at cycle 1 with the buffered line.
  - lb_val is set on every DONE reached via RSP and cleared by reset.
- When undefined: every request runs the full burst; no extra registers.

Decomposition:
- Shared package/defines header holds:
  - the l1i_mau state encoding (2-bit localparams IDLE/REQ/RSP/DONE);
  - the BUS_DATA_WIDTH default;
  - the existing `CORE_ADDR_WIDTH, `CORE_OFFSET_WIDTH and `L1_LINE_SIZE.
- No sub-module is needed: FSM, counter and line buffer sit in one module of about 150–250 lines.
- The line-buffer compare stays inline under the macro.

Test Plan:
- Line of 128 bits (BEATS=4) with a zero-wait bus:
  - Stimulus: addr=0x0000_1230, beats 0xA0,0xA1,0xA2,0xA3.
  - Required: mem_req_addr sequence 0x1230,0x1234,0x1238,0x123C; mau_req_ack at cycle 9; mau_ack_data=0x000000A3_000000A2_000000A1_000000A0.
- Bus stalls:
  - Stimulus: mem_req_ack delayed 3 cycles on beat 1, mem_rsp_val delayed 2 cycles on beat 2.
  - Required: ack at cycle 14; address and mem_req_val held stable during the stall; data identical to the zero-wait case.
- Back-to-back requests:
  - Stimulus: second request at 0x2000 raised the cycle after the ack.
  - Required: accepted; exactly one ack per request; no spurious request from the val still high during DONE.
- Reset mid-operation:
  - Stimulus: rst_n low during RSP of beat 2.
  - Required: outputs return to 0 in the same cycle; after release, a new request at 0x40 completes normally with fresh data and no stale beats.
- Spurious bus response:
  - Stimulus: mem_rsp_val=1 in IDLE and in REQ.
  - Required: line_r is unchanged and the assertion fires.
- With L1I_MAU_LINE_BUF_EN:
  - Stimulus: refill 0x1230, then request 0x1230 again, then request 0x1240.
  - Required: the repeat is acked at cycle 1 with the same data and no mem_req_val; 0x1240 runs the full burst.
